pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX) and PC.
//  Detects load-use hazards and stalls for LOAD_STALL_CYCLES cycles; flushes IF/ID and ID/EX on a taken branch/jump resolved in EX.
//  Provides a run/halt/single-step FSM for debug bring-up, plus saturating stall and flush event counters.
//  Sits beside the decoder; its enable/flush outputs drive the stage registers directly.
// PARAMETERS
//  REG_ADDR_WIDTH     4  register address width
//  LOAD_STALL_CYCLES  1  bubbles inserted per load-use hazard (1..15)
//  R0_IS_ZERO         1  1: rd==0 never creates a hazard
//  CNT_WIDTH          16 width of the stall and flush event counters
// PORTS
//  clk             in  1    clock
//  reset           in  1    synchronous reset, active-high
//  run_cmd         in  1    pulse: enter RUN
//  step_cmd        in  1    pulse: advance one instruction, then IDLE
//  halt_cmd        in  1    pulse: return to IDLE
//  id_rs1_addr     in  RAW  source 1 of the instruction in ID
//  id_rs2_addr     in  RAW  source 2 of the instruction in ID
//  id_rs1_used     in  1    ID instruction reads rs1
//  id_rs2_used     in  1    ID instruction reads rs2
//  ex_rd_addr      in  RAW  rd of the instruction in EX (ID/EX output)
//  ex_is_load      in  1    EX instruction is a load
//  ex_reg_wen      in  1    EX instruction writes rd
//  ex_branch_taken in  1    branch taken or jump in EX (resolved)
//  pc_en           out 1    PC register update enable
//  if_id_en        out 1    IF/ID capture enable
//  if_id_flush     out 1    IF/ID loads a bubble on next edge
//  id_ex_en        out 1    ID/EX capture enable
//  id_ex_flush     out 1    ID/EX loads a bubble (all control 0) on next edge
//  state           out 2    00 IDLE, 01 RUN, 10 STEP
//  stall_count     out CNT  number of stall cycles applied
//  flush_count     out CNT  number of branch flushes applied
//  (RAW = REG_ADDR_WIDTH, CNT = CNT_WIDTH)
// BEHAVIOUR
//  Reset: state=IDLE, stall counter rem=0, halt_pend=0, stall_count=0, flush_count=0.
//   Consequently, all enables and flushes are 0.
//  Outputs are combinational from registered state plus current inputs (0-cycle latency).
//  hazard = ex_is_load & ex_reg_wen & ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)) & !(R0_IS_ZERO & rd==0).
//  IDLE: all enables/flushes 0; ex_branch_taken and hazard are ignored.
//   Commands are decoded with priority halt > step > run: step_cmd -> STEP, run_cmd -> RUN.
//  RUN/STEP (active), per cycle, highest priority first:
//   1 ex_branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1.
//     rem<=0; flush_count+1.
//   2 rem!=0 or hazard (stall): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1.
//     On a new hazard (rem==0), rem<=LOAD_STALL_CYCLES-1; otherwise rem<=rem-1.
//     stall_count+1.
//   3 otherwise (advance): pc_en=if_id_en=id_ex_en=1, flushes 0.
//  STEP -> IDLE after the first non-stall cycle (an advance or a flush); stall cycles keep STEP.
//  halt_cmd in an active state:
//   - If rem==0 and no hazard this cycle -> IDLE next cycle.
//   - Otherwise set halt_pend and go to IDLE after the cycle in which the stall ends (rem==0, no hazard).
//   - Never abandon a stall mid-way.
//  run_cmd in RUN and step_cmd in STEP have no effect; run_cmd in STEP -> RUN.
//   Either command while halt_pend is set is ignored; halt_pend is cleared on entering IDLE.
//  Counters saturate at all-ones; they are cleared by reset only.
//  Reset asserted mid-stall or mid-step: everything returns to reset values on that edge.
// TESTING
//  T1 reset 2 cycles -> state=00, all enables 0, counters 0.
//     run_cmd pulse -> next cycle state=01, pc_en=if_id_en=id_ex_en=1.
//  T2 RUN, ex_is_load=1, ex_reg_wen=1, ex_rd=5, id_rs1=5 used -> same cycle pc_en=0, id_ex_flush=1.
//     stall_count 0->1. With LOAD_STALL_CYCLES=3 stall persists 2 more cycles after ex_is_load drops; count=3.
//  T3 same as T2 but ex_rd=0, id_rs1=0 with R0_IS_ZERO=1 -> no stall, stall_count unchanged.
//     rs2 match with id_rs2_used=0 -> no stall.
//  T4 ex_branch_taken=1 together with a hazard -> both flushes 1, pc_en=1.
//     flush_count+1, stall_count unchanged, next cycle no stall.
//  T5 LOAD_STALL_CYCLES=3, halt_cmd in first stall cycle -> stays RUN 2 more stall cycles, then state=00, enables 0.
//  T6 IDLE, step_cmd with no hazard -> exactly 1 cycle with id_ex_en=1, then IDLE.
//     Repeat with a hazard -> STEP held through the stall plus 1 advance cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall insertion, taken-branch flush,
// run/halt/single-step debug FSM and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH    = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int R0_IS_ZERO        = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_cmd,
    input  logic                      step_cmd,
    input  logic                      halt_cmd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_is_load,
    input  logic                      ex_reg_wen,
    input  logic                      ex_branch_taken,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      if_id_flush,
    output logic                      id_ex_en,
    output logic                      id_ex_flush,
    output logic [1:0]                state,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam int             REM_W    = 4;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL_CYCLES - 1);

    state_t               state_q, state_nxt;
    logic [REM_W-1:0]     rem_q;
    logic                 halt_pend_q, halt_pend_nxt;
    logic [CNT_WIDTH-1:0] stall_count_q, flush_count_q;

    logic active, hazard, rd_is_r0, flush_cyc, stall_cyc, adv_cyc;

    assign rd_is_r0 = (R0_IS_ZERO != 0) && (ex_rd_addr == '0);
    assign hazard   = ex_is_load && ex_reg_wen && !rd_is_r0 &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    // A taken branch squashes the hazard: the dependent instruction is flushed anyway.
    assign flush_cyc = active && ex_branch_taken;
    assign stall_cyc = active && !ex_branch_taken && ((rem_q != '0) || hazard);
    assign adv_cyc   = active && !ex_branch_taken && !stall_cyc;

    assign pc_en       = flush_cyc || adv_cyc;
    assign if_id_en    = flush_cyc || adv_cyc;
    assign if_id_flush = flush_cyc;
    assign id_ex_en    = active;
    assign id_ex_flush = flush_cyc || stall_cyc;

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_comb begin
        state_nxt     = state_q;
        halt_pend_nxt = halt_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (!halt_cmd) begin
                    if (step_cmd)     state_nxt = ST_STEP;
                    else if (run_cmd) state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                // A halt never cuts a stall short; it waits for the first non-stall cycle.
                if (halt_cmd || halt_pend_q) begin
                    if (!stall_cyc) state_nxt = ST_IDLE;
                    else            halt_pend_nxt = 1'b1;
                end else if (state_q == ST_STEP) begin
                    if (run_cmd)         state_nxt = ST_RUN;
                    else if (!stall_cyc) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_IDLE) halt_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            halt_pend_q   <= 1'b0;
            rem_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q     <= state_nxt;
            halt_pend_q <= halt_pend_nxt;
            if (flush_cyc)
                rem_q <= '0;
            else if (stall_cyc)
                rem_q <= (rem_q == '0) ? REM_INIT : rem_q - REM_W'(1);
            if (stall_cyc && (stall_count_q != '1))
                stall_count_q <= stall_count_q + CNT_WIDTH'(1);
            if (flush_cyc && (flush_count_q != '1))
                flush_count_q <= flush_count_q + CNT_WIDTH'(1);
        end
    end

endmodule
